// File: rtl/wt_cache_pkg.sv
// Shared types and defaults for the write-through D$ SHiP predictor.
// Geometry constants mirror the cache that feeds the replacement/hit reports.
package wt_cache_pkg;

  localparam int unsigned DCACHE_SET_ASSOC    = 8;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
  localparam int unsigned DCACHE_WAY_WIDTH    = $clog2(DCACHE_SET_ASSOC);

  localparam int unsigned SHIP_SIG_WIDTH_DFLT = 8;
  localparam logic [1:0]  SHIP_CTR_INIT_DFLT  = 2'd1;

  typedef logic [SHIP_SIG_WIDTH_DFLT-1:0] ship_sig_t;

  typedef struct packed {
    ship_sig_t sig;
    logic      valid;
    logic      reused;
  } ship_line_t;

endpackage

// File: rtl/wt_dcache_ship_shct_if.sv
// Replacement/hit report bundle between the D$ controller and the SHiP SHCT.
interface wt_dcache_ship_shct_if;
  import wt_cache_pkg::*;

  logic                           repl_i;
  logic [DCACHE_CL_IDX_WIDTH-1:0] repl_idx_i;
  logic [DCACHE_WAY_WIDTH-1:0]    repl_way_i;
  logic [63:0]                    repl_pc_i;
  logic                           hit_i;
  logic [DCACHE_CL_IDX_WIDTH-1:0] hit_idx_i;
  logic [DCACHE_WAY_WIDTH-1:0]    hit_way_i;
  logic [1:0]                     pred_result_o;

  modport master (
    output repl_i, repl_idx_i, repl_way_i, repl_pc_i,
    output hit_i, hit_idx_i, hit_way_i,
    input  pred_result_o
  );

  modport slave (
    input  repl_i, repl_idx_i, repl_way_i, repl_pc_i,
    input  hit_i, hit_idx_i, hit_way_i,
    output pred_result_o
  );

endinterface

// File: rtl/wt_dcache_ship_shct_satctr.sv
// One SHCT entry: 2-bit saturating up/down counter with init value on reset/clear.
module wt_dcache_ship_satctr #(
  parameter logic [1:0] INIT = 2'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);

  // Opposing inc/dec in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= INIT;
    end else if (clr) begin
      cnt <= INIT;
    end else if (inc && !dec && cnt != 2'd3) begin
      cnt <= cnt + 2'd1;
    end else if (dec && !inc && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end

endmodule

// File: rtl/wt_dcache_ship_shct.sv
// SHiP signature history counter table plus per-line signature/reuse tracking.
// Define WT_DCACHE_SHIP_FLUSH_CLR_EN to also reinitialise the SHCT on flush.
module wt_dcache_ship_shct
  import wt_cache_pkg::*;
#(
  parameter int unsigned SHIP_SIG_WIDTH = SHIP_SIG_WIDTH_DFLT,
  parameter logic [1:0]  SHIP_CTR_INIT  = SHIP_CTR_INIT_DFLT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  wt_dcache_ship_shct_if.slave  bus
);

  localparam int unsigned SHCT_DEPTH = 2 ** SHIP_SIG_WIDTH;
  localparam int unsigned NUM_SETS   = 2 ** DCACHE_CL_IDX_WIDTH;

  function automatic logic [SHIP_SIG_WIDTH-1:0] sig_of(input logic [63:0] pc);
    return pc[SHIP_SIG_WIDTH+1:2] ^ pc[2*SHIP_SIG_WIDTH+1:SHIP_SIG_WIDTH+2];
  endfunction

  ship_line_t                meta_q [NUM_SETS][DCACHE_SET_ASSOC];
  logic [1:0]                shct   [SHCT_DEPTH];

  ship_line_t                victim;
  ship_line_t                hit_line;
  logic                      same_line;
  logic                      hit_ok;
  logic                      inc_en;
  logic                      dec_en;
  logic [SHIP_SIG_WIDTH-1:0] inc_sig;
  logic [SHIP_SIG_WIDTH-1:0] dec_sig;
  logic [SHIP_SIG_WIDTH-1:0] repl_sig;
  logic                      ctr_clr;

  // Prediction reads only the PC signature, never the victim way.
  assign repl_sig          = sig_of(bus.repl_pc_i);
  assign bus.pred_result_o = shct[repl_sig];

  always_comb begin
    victim    = meta_q[bus.repl_idx_i][bus.repl_way_i];
    hit_line  = meta_q[bus.hit_idx_i][bus.hit_way_i];
    same_line = bus.repl_i && (bus.repl_idx_i == bus.hit_idx_i)
                && (bus.repl_way_i == bus.hit_way_i);
    hit_ok    = bus.hit_i && !flush_i && hit_line.valid && !same_line;
    inc_en    = hit_ok && !hit_line.reused;
    inc_sig   = SHIP_SIG_WIDTH'(hit_line.sig);
    dec_en    = bus.repl_i && !flush_i && victim.valid && !victim.reused;
    dec_sig   = SHIP_SIG_WIDTH'(victim.sig);
  end

`ifdef WT_DCACHE_SHIP_FLUSH_CLR_EN
  assign ctr_clr = flush_i;
`else
  assign ctr_clr = 1'b0;
`endif

  // Flush drops line state but keeps stored signatures; replacement overrides a same-line hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
          meta_q[s][w] <= '0;
        end
      end
    end else if (flush_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
          meta_q[s][w].valid  <= 1'b0;
          meta_q[s][w].reused <= 1'b0;
        end
      end
    end else begin
      if (hit_ok) begin
        meta_q[bus.hit_idx_i][bus.hit_way_i].reused <= 1'b1;
      end
      if (bus.repl_i) begin
        meta_q[bus.repl_idx_i][bus.repl_way_i] <= '{sig: ship_sig_t'(repl_sig),
                                                    valid: 1'b1, reused: 1'b0};
      end
    end
  end

  for (genvar e = 0; e < SHCT_DEPTH; e++) begin : g_shct
    wt_dcache_ship_satctr #(
      .INIT (SHIP_CTR_INIT)
    ) u_ctr (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (ctr_clr),
      .inc   (inc_en && (inc_sig == SHIP_SIG_WIDTH'(e))),
      .dec   (dec_en && (dec_sig == SHIP_SIG_WIDTH'(e))),
      .cnt   (shct[e])
    );
  end

endmodule
